// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle sequencer: FSM states, RV32I opcodes and
// the datapath mux / ALU / immediate select codes driven onto the shared datapath.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal,
    StJalr,
    StLink,
    StTrap
  } state_e;

  // Opcodes (IR[6:0])
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  // ALUControl
  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluSltu = 4'b0110;
  localparam logic [3:0] AluSll  = 4'b0111;
  localparam logic [3:0] AluSrl  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;

  // ImmSrc
  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  // ALUSrcA / ALUSrcB
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;
  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;

  // ResultSrc
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResReadData  = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] DtWord = 2'b10;

  // ALU mode requested by the FSM from mc_alu_decode
  localparam logic [1:0] AluModeAdd    = 2'b00;
  localparam logic [1:0] AluModeFunct  = 2'b01;
  localparam logic [1:0] AluModeBranch = 2'b10;

  function automatic logic [2:0] imm_src_for(input logic [6:0] op);
    logic [2:0] imm;
    case (op)
      OpStore:  imm = ImmS;
      OpBranch: imm = ImmB;
      OpJal:    imm = ImmJ;
      OpLui:    imm = ImmU;
      default:  imm = ImmI;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// mc_alu_decode: combinational ALU operation select.
//   op_i, funct3_i, funct75_i : instruction register fields
//   alu_mode_i                : add / funct3 decode / branch compare, chosen by the FSM
//   alu_control_o             : ALUControl encoding
module mc_alu_decode
  import multicycle_control_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct75_i,
  input  logic [1:0] alu_mode_i,
  output logic [3:0] alu_control_o
);

  always_comb begin
    alu_control_o = AluAdd;
    unique case (alu_mode_i)
      AluModeFunct: begin
        // LUI computes 0 + imm, so it always adds regardless of funct3
        if (op_i != OpLui) begin
          unique case (funct3_i)
            3'b000:  alu_control_o = (op_i == OpRType && funct75_i) ? AluSub : AluAdd;
            3'b001:  alu_control_o = AluSll;
            3'b010:  alu_control_o = AluSlt;
            3'b011:  alu_control_o = AluSltu;
            3'b100:  alu_control_o = AluXor;
            3'b101:  alu_control_o = funct75_i ? AluSra : AluSrl;
            3'b110:  alu_control_o = AluOr;
            default: alu_control_o = AluAnd;
          endcase
        end
      end
      AluModeBranch: begin
        // beq/bne compare by subtraction; blt/bge/bltu/bgeu by set-less-than
        if (!funct3_i[2]) alu_control_o = AluSub;
        else if (funct3_i[1]) alu_control_o = AluSltu;
        else alu_control_o = AluSlt;
      end
      default: alu_control_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle RV32I sequencer sharing one ALU and one memory port.
//   clk, rst (sync, active high)       : clock and reset
//   op, funct3, funct75, Zero          : IR fields and ALU zero flag
//   mem_ready                          : memory completes the requested access this cycle
//   mem_req, MemWrite, AdrSrc          : memory port control
//   IRWrite, PCWrite, RegWrite         : architectural write enables
//   ALUSrcA, ALUSrcB, ALUControl       : ALU operand and operation select
//   ResultSrc, ImmSrc, DataType        : result mux, immediate format, access size
//   illegal                            : one-cycle pulse on an unsupported opcode
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct75,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [1:0] DataType,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [1:0] alu_mode;
  logic [3:0] alu_ctrl;

  mc_alu_decode u_alu_decode (
    .op_i          (op),
    .funct3_i      (funct3),
    .funct75_i     (funct75),
    .alu_mode_i    (alu_mode),
    .alu_control_o (alu_ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  assign ALUControl = rst ? 4'b0000 : alu_ctrl;

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SrcAPc;
    ALUSrcB   = SrcBRs2;
    ResultSrc = ResAluOut;
    ImmSrc    = ImmI;
    DataType  = DtWord;
    illegal   = 1'b0;
    alu_mode  = AluModeAdd;

    unique case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Precompute branch / JAL target into ALUOut
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
        ImmSrc  = imm_src_for(op);
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIAlu, OpLui:   state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        // ImmExt is combinational off IR, so keep the format selected while it is consumed
        ALUSrcA  = SrcARs1;
        ALUSrcB  = SrcBImm;
        ImmSrc   = imm_src_for(op);
        DataType = funct3[1:0];
        state_d  = (op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        DataType = funct3[1:0];
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = ResReadData;
        RegWrite  = 1'b1;
        DataType  = funct3[1:0];
        state_d   = StFetch;
      end
      StMemWrite: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        DataType = funct3[1:0];
        if (mem_ready) state_d = StFetch;
      end
      StExecR: begin
        ALUSrcA  = SrcARs1;
        alu_mode = AluModeFunct;
        state_d  = StAluWb;
      end
      StExecI: begin
        ALUSrcA  = (op == OpLui) ? SrcAZero : SrcARs1;
        ALUSrcB  = SrcBImm;
        ImmSrc   = imm_src_for(op);
        alu_mode = AluModeFunct;
        state_d  = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        ALUSrcA  = SrcARs1;
        alu_mode = AluModeBranch;
        // funct3[0] inverts the sense (bne/bge); funct3[2] maps SLT=1 (Zero=0) to taken
        PCWrite  = Zero ^ funct3[0] ^ funct3[2];
        state_d  = StFetch;
      end
      StJal: begin
        // Jump to the target held in ALUOut while computing OldPC+4 for the link
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBFour;
        PCWrite = 1'b1;
        state_d = StAluWb;
      end
      StJalr: begin
        ALUSrcA   = SrcARs1;
        ALUSrcB   = SrcBImm;
        ImmSrc    = imm_src_for(op);
        ResultSrc = ResAluResult;
        PCWrite   = 1'b1;
        state_d   = StLink;
      end
      StLink: begin
        ALUSrcA   = SrcAOldPc;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
        RegWrite  = 1'b1;
        state_d   = StFetch;
      end
      StTrap: begin
        illegal = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Reset quiets the whole datapath interface in the same cycle
    if (rst) begin
      mem_req   = 1'b0;
      MemWrite  = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      ImmSrc    = 3'b000;
      DataType  = 2'b00;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each cycle the stimulus pushes the
// expected output vector into a queue; a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBad    = 7'b1111111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [3:0] alu;
    logic [1:0] res;
    logic [2:0] imm;
    logic [1:0] dt;
    logic       illegal;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = OpR;
  logic [2:0] funct3 = 3'b000;
  logic       funct75 = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, DataType;
  logic [3:0] ALUControl;
  logic [2:0] ImmSrc;

  logic [6:0] nxt_op = OpR;
  logic [2:0] nxt_f3 = 3'b000;
  logic       nxt_f7 = 1'b0;

  out_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct75    (funct75),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .DataType   (DataType),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      string t;
      out_t  g;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = '{mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
            ALUControl, ResultSrc, ImmSrc, DataType, illegal};
      check_eq(t, g, e);
    end
  end

  // Expected-output builders, one per FSM state
  function automatic out_t o_base();
    out_t o = '0;
    o.dt = 2'b10;
    return o;
  endfunction

  function automatic out_t o_fetch(input logic rdy);
    out_t o = o_base();
    o.mem_req = 1'b1; o.src_b = 2'b10; o.res = 2'b10;
    o.ir_write = rdy; o.pc_write = rdy;
    return o;
  endfunction

  function automatic out_t o_decode(input logic [2:0] imm);
    out_t o = o_base();
    o.src_a = 2'b01; o.src_b = 2'b01; o.imm = imm;
    return o;
  endfunction

  function automatic out_t o_exec_r(input logic [3:0] alu);
    out_t o = o_base();
    o.src_a = 2'b10; o.alu = alu;
    return o;
  endfunction

  function automatic out_t o_exec_i(input logic [3:0] alu, input logic lui);
    out_t o = o_base();
    o.src_a = lui ? 2'b11 : 2'b10; o.src_b = 2'b01; o.alu = alu;
    o.imm = lui ? 3'b100 : 3'b000;
    return o;
  endfunction

  function automatic out_t o_alu_wb();
    out_t o = o_base();
    o.reg_write = 1'b1;
    return o;
  endfunction

  function automatic out_t o_mem_adr(input logic [2:0] imm, input logic [1:0] dt);
    out_t o = o_base();
    o.src_a = 2'b10; o.src_b = 2'b01; o.imm = imm; o.dt = dt;
    return o;
  endfunction

  function automatic out_t o_mem(input logic wr, input logic [1:0] dt);
    out_t o = o_base();
    o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_write = wr; o.dt = dt;
    return o;
  endfunction

  function automatic out_t o_mem_wb(input logic [1:0] dt);
    out_t o = o_base();
    o.res = 2'b01; o.reg_write = 1'b1; o.dt = dt;
    return o;
  endfunction

  function automatic out_t o_branch(input logic [3:0] alu, input logic taken);
    out_t o = o_base();
    o.src_a = 2'b10; o.alu = alu; o.pc_write = taken;
    return o;
  endfunction

  function automatic out_t o_jal();
    out_t o = o_base();
    o.src_a = 2'b01; o.src_b = 2'b10; o.pc_write = 1'b1;
    return o;
  endfunction

  function automatic out_t o_jalr();
    out_t o = o_base();
    o.src_a = 2'b10; o.src_b = 2'b01; o.res = 2'b10; o.pc_write = 1'b1;
    return o;
  endfunction

  function automatic out_t o_link();
    out_t o = o_base();
    o.src_a = 2'b01; o.src_b = 2'b10; o.res = 2'b10; o.reg_write = 1'b1;
    return o;
  endfunction

  function automatic out_t o_trap();
    out_t o = o_base();
    o.illegal = 1'b1;
    return o;
  endfunction

  task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    nxt_op = o; nxt_f3 = f3; nxt_f7 = f7;
  endtask

  // One clock cycle: drive inputs just after the edge, queue what the outputs must be
  task automatic cyc(input logic r, input logic rdy, input logic z, input out_t e,
                     input string tag);
    @(posedge clk);
    #1;
    rst = r; mem_ready = rdy; Zero = z;
    op = nxt_op; funct3 = nxt_f3; funct75 = nxt_f7;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic run_r(input logic [2:0] f3, input logic f7, input logic [3:0] alu,
                       input string tag);
    set_ir(OpR, f3, f7);
    cyc(1'b0, 1'b1, 1'b0, o_fetch(1'b1), {tag, ".fetch"});
    cyc(1'b0, 1'b1, 1'b0, o_decode(3'b000), {tag, ".decode"});
    cyc(1'b0, 1'b1, 1'b0, o_exec_r(alu), {tag, ".exec"});
    cyc(1'b0, 1'b1, 1'b0, o_alu_wb(), {tag, ".wb"});
  endtask

  task automatic run_i(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic [3:0] alu, input string tag);
    logic lui;
    lui = (o == OpLui);
    set_ir(o, f3, f7);
    cyc(1'b0, 1'b1, 1'b0, o_fetch(1'b1), {tag, ".fetch"});
    cyc(1'b0, 1'b1, 1'b0, o_decode(lui ? 3'b100 : 3'b000), {tag, ".decode"});
    cyc(1'b0, 1'b1, 1'b0, o_exec_i(alu, lui), {tag, ".exec"});
    cyc(1'b0, 1'b1, 1'b0, o_alu_wb(), {tag, ".wb"});
  endtask

  task automatic run_br(input logic [2:0] f3, input logic z, input logic [3:0] alu,
                        input logic taken, input string tag);
    set_ir(OpBranch, f3, 1'b0);
    cyc(1'b0, 1'b1, z, o_fetch(1'b1), {tag, ".fetch"});
    cyc(1'b0, 1'b1, z, o_decode(3'b010), {tag, ".decode"});
    cyc(1'b0, 1'b1, z, o_branch(alu, taken), {tag, ".branch"});
  endtask

  initial begin
    // Reset: everything zero even with mem_ready high
    cyc(1'b1, 1'b1, 1'b0, out_t'('0), "reset0");
    cyc(1'b1, 1'b1, 1'b0, out_t'('0), "reset1");

    run_r(3'b000, 1'b0, 4'b0000, "add");
    run_r(3'b000, 1'b1, 4'b0001, "sub");
    run_r(3'b101, 1'b1, 4'b1001, "sra");
    run_r(3'b111, 1'b0, 4'b0010, "and");
    run_i(OpI, 3'b000, 1'b1, 4'b0000, "addi_f7");
    run_i(OpI, 3'b101, 1'b0, 4'b1000, "srli");
    run_i(OpI, 3'b010, 1'b0, 4'b0101, "slti");
    run_i(OpLui, 3'b100, 1'b1, 4'b0000, "lui");

    // lw: one fetch wait state, then MEMREAD stalled 2 cycles
    set_ir(OpLoad, 3'b010, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, o_fetch(1'b0), "lw.fetch_wait");
    cyc(1'b0, 1'b1, 1'b0, o_fetch(1'b1), "lw.fetch");
    cyc(1'b0, 1'b0, 1'b0, o_decode(3'b000), "lw.decode");
    cyc(1'b0, 1'b1, 1'b0, o_mem_adr(3'b000, 2'b10), "lw.memadr");
    cyc(1'b0, 1'b0, 1'b0, o_mem(1'b0, 2'b10), "lw.memread_w0");
    cyc(1'b0, 1'b0, 1'b0, o_mem(1'b0, 2'b10), "lw.memread_w1");
    cyc(1'b0, 1'b1, 1'b0, o_mem(1'b0, 2'b10), "lw.memread");
    cyc(1'b0, 1'b1, 1'b0, o_mem_wb(2'b10), "lw.memwb");

    // lbu: byte-size access
    set_ir(OpLoad, 3'b100, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, o_fetch(1'b1), "lbu.fetch");
    cyc(1'b0, 1'b1, 1'b0, o_decode(3'b000), "lbu.decode");
    cyc(1'b0, 1'b1, 1'b0, o_mem_adr(3'b000, 2'b00), "lbu.memadr");
    cyc(1'b0, 1'b1, 1'b0, o_mem(1'b0, 2'b00), "lbu.memread");
    cyc(1'b0, 1'b1, 1'b0, o_mem_wb(2'b00), "lbu.memwb");

    // sh: zero wait states
    set_ir(OpStore, 3'b001, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, o_fetch(1'b1), "sh.fetch");
    cyc(1'b0, 1'b1, 1'b0, o_decode(3'b001), "sh.decode");
    cyc(1'b0, 1'b1, 1'b0, o_mem_adr(3'b001, 2'b01), "sh.memadr");
    cyc(1'b0, 1'b1, 1'b0, o_mem(1'b1, 2'b01), "sh.memwrite");

    run_br(3'b000, 1'b1, 4'b0001, 1'b1, "beq_z1");
    run_br(3'b000, 1'b0, 4'b0001, 1'b0, "beq_z0");
    run_br(3'b001, 1'b1, 4'b0001, 1'b0, "bne_z1");
    run_br(3'b100, 1'b0, 4'b0101, 1'b1, "blt_z0");
    run_br(3'b101, 1'b0, 4'b0101, 1'b0, "bge_z0");
    run_br(3'b111, 1'b1, 4'b0110, 1'b1, "bgeu_z1");

    set_ir(OpJal, 3'b000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, o_fetch(1'b1), "jal.fetch");
    cyc(1'b0, 1'b1, 1'b0, o_decode(3'b011), "jal.decode");
    cyc(1'b0, 1'b1, 1'b0, o_jal(), "jal.jump");
    cyc(1'b0, 1'b1, 1'b0, o_alu_wb(), "jal.wb");

    set_ir(OpJalr, 3'b000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, o_fetch(1'b1), "jalr.fetch");
    cyc(1'b0, 1'b1, 1'b0, o_decode(3'b000), "jalr.decode");
    cyc(1'b0, 1'b1, 1'b0, o_jalr(), "jalr.jump");
    cyc(1'b0, 1'b1, 1'b0, o_link(), "jalr.link");

    set_ir(OpBad, 3'b000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, o_fetch(1'b1), "bad.fetch");
    cyc(1'b0, 1'b1, 1'b0, o_decode(3'b000), "bad.decode");
    cyc(1'b0, 1'b1, 1'b0, o_trap(), "bad.trap");
    cyc(1'b0, 1'b0, 1'b0, o_fetch(1'b0), "bad.refetch");

    // sw stalled in MEMWRITE, aborted by reset
    set_ir(OpStore, 3'b010, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, o_fetch(1'b1), "swr.fetch");
    cyc(1'b0, 1'b1, 1'b0, o_decode(3'b001), "swr.decode");
    cyc(1'b0, 1'b0, 1'b0, o_mem_adr(3'b001, 2'b10), "swr.memadr");
    cyc(1'b0, 1'b0, 1'b0, o_mem(1'b1, 2'b10), "swr.memwrite_w0");
    cyc(1'b0, 1'b0, 1'b0, o_mem(1'b1, 2'b10), "swr.memwrite_w1");
    cyc(1'b1, 1'b1, 1'b0, out_t'('0), "swr.rst");
    cyc(1'b0, 1'b0, 1'b0, o_fetch(1'b0), "swr.fetch_after_rst");
    cyc(1'b0, 1'b1, 1'b0, o_fetch(1'b1), "swr.fetch2");

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
